muldiv_sequencer: RTL

- Multi-cycle multiply/divide unit for the EX stage. Runs beside the single-cycle ALU and handles the RV32M ops the ALU cannot do in one cycle.
- Accepts one operation at a time over a valid/ready request channel and iterates a shared 33-bit add/subtract datapath for 32 cycles.
- Returns the 32-bit result over a valid/ready response channel.
- The pipeline control stalls EX while this block is busy, and it can flush an in-flight operation.

---
 rtl/muldiv_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit for the EX stage (32 cycles per op).
// Define MULDIV_SIGNED_EN to enable signed MULH/MULHSU/DIV/REM handling.
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   res_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              busy_q;

  logic              sgn_a;
  logic              sgn_b;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              neg_in;
  logic              div0;
  logic [XLEN-1:0]   div0_res;

  logic [XLEN:0]     add_x;
  logic [XLEN:0]     add_y;
  logic [XLEN:0]     add_s;
  logic              add_cin;
  logic              borrow;
  logic [XLEN-1:0]   hi_d;
  logic [XLEN-1:0]   lo_d;
  logic [XLEN-1:0]   mul_hi;
  logic [XLEN-1:0]   fin;

`ifdef MULDIV_SIGNED_EN
  assign sgn_a = (req_op == 3'd1) || (req_op == 3'd2) ||
                 (req_op == 3'd4) || (req_op == 3'd6);
  assign sgn_b = (req_op == 3'd1) || (req_op == 3'd4) ||
                 (req_op == 3'd6);
`else
  assign sgn_a = 1'b0;
  assign sgn_b = 1'b0;
`endif

  assign a_neg    = sgn_a & req_a[XLEN-1];
  assign b_neg    = sgn_b & req_b[XLEN-1];
  assign a_mag    = a_neg ? (~req_a + 1'b1) : req_a;
  assign b_mag    = b_neg ? (~req_b + 1'b1) : req_b;
  // Remainder takes the dividend's sign; everything else the XOR.
  assign neg_in   = (req_op[2:1] == 2'b11) ? a_neg : (a_neg ^ b_neg);
  assign div0     = req_op[2] && (req_b == '0);
  assign div0_res = req_op[1] ? req_a : '1;

  // One 33-bit adder: add for shift-add multiply, subtract for divide.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    if (op_q[2]) begin
      add_x   = {hi_q, lo_q[XLEN-1]};
      add_y   = ~{1'b0, b_q};
      add_cin = 1'b1;
    end else begin
      add_x = {1'b0, hi_q};
      add_y = lo_q[0] ? {1'b0, b_q} : '0;
    end
    add_s = add_x + add_y + {{XLEN{1'b0}}, add_cin};
  end

  assign borrow = add_s[XLEN];

  always_comb begin
    hi_d = '0;
    lo_d = '0;
    if (op_q[2]) begin
      hi_d = borrow ? add_x[XLEN-1:0] : add_s[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], ~borrow};
    end else begin
      hi_d = add_s[XLEN:1];
      lo_d = {add_s[0], lo_q[XLEN-1:1]};
    end
  end

  // Upper half of the negated 64-bit product.
  assign mul_hi = neg_q ? (~hi_d + XLEN'(lo_d == '0)) : hi_d;

  always_comb begin
    fin = '0;
    unique case (1'b1)
      (op_q == 3'd0):
        fin = lo_d;
      (!op_q[2] && op_q != 3'd0):
        fin = mul_hi;
      (op_q[2:1] == 2'b10):
        fin = neg_q ? (~lo_d + 1'b1) : lo_d;
      (op_q[2:1] == 2'b11):
        fin = neg_q ? (~hi_d + 1'b1) : hi_d;
      default:
        fin = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      neg_q        <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
      b_q          <= '0;
      res_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else if (flush) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            op_q        <= req_op;
            neg_q       <= neg_in;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (div0) begin
              res_q        <= div0_res;
              resp_valid_q <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              hi_q    <= '0;
              lo_q    <= req_op[2] ? a_mag : b_mag;
              b_q     <= req_op[2] ? b_mag : a_mag;
              cnt_q   <= '0;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            res_q        <= fin;
            resp_valid_q <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = res_q;
  assign busy        = busy_q;

endmodule
